// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// fb_pkg : shared geometry, pixel layout and FSM encoding for the FB writer
// Rev 1.0
// ============================================================================
package fb_pkg;
    localparam int H_VISIBLE_DEF = 640;
    localparam int V_VISIBLE_DEF = 480;
    localparam int COORD_W       = 10;
    localparam int PIX_W         = 3;
    localparam int PIX_R         = 0;
    localparam int PIX_G         = 1;
    localparam int PIX_B         = 2;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;
endpackage
`default_nettype wire

// File: rtl/fb_clear_counter.sv
`default_nettype none
// ============================================================================
// fb_clear_counter : raster-order (x,y) walker over the visible area
// Rev 1.0
// ============================================================================
module fb_clear_counter
    import fb_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable_i,
    input  logic               restart_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_VISIBLE - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_VISIBLE - 1);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (restart_i) begin
            x_d = '0;
            y_d = '0;
        end else if (enable_i) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);
endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// fb_write_arbiter : round-robin frame buffer write arbiter with optional
// visible-area fill (enabled by macro FB_CLEAR_EN).  Rev 1.0
// ============================================================================
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_display,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [COORD_W-1:0] req0_x,
    input  logic [COORD_W-1:0] req0_y,
    input  logic [PIX_W-1:0]   req0_pixel,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [COORD_W-1:0] req1_x,
    input  logic [COORD_W-1:0] req1_y,
    input  logic [PIX_W-1:0]   req1_pixel,
    input  logic               clear_start,
    input  logic [PIX_W-1:0]   clear_pixel,
    output logic               clear_busy,
    output logic               fb_we,
    output logic [COORD_W-1:0] fb_x,
    output logic [COORD_W-1:0] fb_y,
    output logic [PIX_W-1:0]   fb_pixel,
    output logic               drop_flag
);
    fb_state_e          state_q;
    logic               prio1_q;
    logic               fb_we_q, drop_q;
    logic [COORD_W-1:0] fb_x_q, fb_y_q;
    logic [PIX_W-1:0]   fb_pix_q;

    logic               clear_go, arb_open, grant0, grant1, xfer, in_range;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [PIX_W-1:0]   sel_pix;

`ifdef FB_CLEAR_EN
    logic               cnt_en, cnt_last;
    logic [COORD_W-1:0] cnt_x, cnt_y;
    logic [PIX_W-1:0]   clr_pix_q;

    assign clear_go = (state_q == ST_ARB) && clear_start;
    assign cnt_en   = (state_q == ST_CLEAR) && !in_display;

    fb_clear_counter #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE)
    ) u_clear_counter (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable_i  (cnt_en),
        .restart_i (clear_go),
        .x_o       (cnt_x),
        .y_o       (cnt_y),
        .last_o    (cnt_last)
    );
`else
    logic unused_clear;
    assign clear_go     = 1'b0;
    assign unused_clear = ^{clear_start, clear_pixel};
`endif

    // A fill request pre-empts any pending pixel request in the same cycle.
    assign arb_open = (state_q == ST_ARB) && !in_display && !clear_go;
    assign grant0   = arb_open && req0_valid && (!req1_valid || !prio1_q);
    assign grant1   = arb_open && req1_valid && !grant0;
    assign xfer     = grant0 || grant1;

    assign sel_x    = grant1 ? req1_x     : req0_x;
    assign sel_y    = grant1 ? req1_y     : req0_y;
    assign sel_pix  = grant1 ? req1_pixel : req0_pixel;
    assign in_range = (sel_x < COORD_W'(H_VISIBLE)) && (sel_y < COORD_W'(V_VISIBLE));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_ARB;
            prio1_q  <= 1'b0;
            fb_we_q  <= 1'b0;
            fb_x_q   <= '0;
            fb_y_q   <= '0;
            fb_pix_q <= '0;
            drop_q   <= 1'b0;
`ifdef FB_CLEAR_EN
            clr_pix_q <= '0;
`endif
        end else begin
            fb_we_q <= 1'b0;
            if (xfer) begin
                prio1_q <= grant0;
                if (in_range) begin
                    fb_we_q  <= 1'b1;
                    fb_x_q   <= sel_x;
                    fb_y_q   <= sel_y;
                    fb_pix_q <= sel_pix;
                end else begin
                    drop_q <= 1'b1;
                end
            end
`ifdef FB_CLEAR_EN
            case (state_q)
                ST_ARB: begin
                    if (clear_start) begin
                        state_q   <= ST_CLEAR;
                        clr_pix_q <= clear_pixel;
                    end
                end
                ST_CLEAR: begin
                    if (!in_display) begin
                        fb_we_q  <= 1'b1;
                        fb_x_q   <= cnt_x;
                        fb_y_q   <= cnt_y;
                        fb_pix_q <= clr_pix_q;
                        if (cnt_last) begin
                            state_q <= ST_ARB;
                        end
                    end
                end
                default: state_q <= ST_ARB;
            endcase
`endif
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign clear_busy = (state_q == ST_CLEAR);
    assign fb_we      = fb_we_q;
    assign fb_x       = fb_x_q;
    assign fb_y       = fb_y_q;
    assign fb_pixel   = fb_pix_q;
    assign drop_flag  = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fb_write_arbiter : scoreboard bench for fb_write_arbiter
// Rev 1.0
// ============================================================================
module tb_fb_write_arbiter;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] p;
    } wr_t;

    int errors = 0;
    int checks = 0;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_display = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [9:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [2:0] req0_pixel = '0, req1_pixel = '0;
    logic       clear_start = 1'b0;
    logic [2:0] clear_pixel = '0;
    logic       req0_ready, req1_ready, clear_busy, fb_we, drop_flag;
    logic [9:0] fb_x, fb_y;
    logic [2:0] fb_pixel;

    wr_t exp_q[$];

    always #5 clock = ~clock;

    fb_write_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_display  (in_display),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req0_pixel  (req0_pixel),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req1_pixel  (req1_pixel),
        .clear_start (clear_start),
        .clear_pixel (clear_pixel),
        .clear_busy  (clear_busy),
        .fb_we       (fb_we),
        .fb_x        (fb_x),
        .fb_y        (fb_y),
        .fb_pixel    (fb_pixel),
        .drop_flag   (drop_flag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic wr_t mk(input int x, input int y, input int p);
        wr_t w;
        w.x = 10'(x);
        w.y = 10'(y);
        w.p = 3'(p);
        return w;
    endfunction

    // Scoreboard monitor for the full-size instance
    always @(negedge clock) begin
        if (fb_we) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got (%0d,%0d,%b) expected none", fb_x, fb_y, fb_pixel);
            end else begin
                e = exp_q.pop_front();
                if ({fb_x, fb_y, fb_pixel} !== e) begin
                    errors++;
                    $display("FAIL write: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                             fb_x, fb_y, fb_pixel, e.x, e.y, e.p);
                end
            end
        end
    end

`ifdef FB_CLEAR_EN
    // Small 4x2 instance for the visible-area fill scenarios
    logic       s_rst_n = 1'b0;
    logic       s_in_display = 1'b0;
    logic       s_req0_valid = 1'b0;
    logic [9:0] s_req0_x = '0, s_req0_y = '0;
    logic [2:0] s_req0_pixel = '0;
    logic       s_clear_start = 1'b0;
    logic [2:0] s_clear_pixel = '0;
    logic       s_req0_ready, s_req1_ready, s_clear_busy, s_fb_we, s_drop_flag;
    logic [9:0] s_fb_x, s_fb_y;
    logic [2:0] s_fb_pixel;
    wr_t        s_exp_q[$];

    fb_write_arbiter #(.H_VISIBLE(4), .V_VISIBLE(2)) dut_small (
        .clock       (clock),
        .reset_n     (s_rst_n),
        .in_display  (s_in_display),
        .req0_valid  (s_req0_valid),
        .req0_ready  (s_req0_ready),
        .req0_x      (s_req0_x),
        .req0_y      (s_req0_y),
        .req0_pixel  (s_req0_pixel),
        .req1_valid  (1'b0),
        .req1_ready  (s_req1_ready),
        .req1_x      (10'd0),
        .req1_y      (10'd0),
        .req1_pixel  (3'd0),
        .clear_start (s_clear_start),
        .clear_pixel (s_clear_pixel),
        .clear_busy  (s_clear_busy),
        .fb_we       (s_fb_we),
        .fb_x        (s_fb_x),
        .fb_y        (s_fb_y),
        .fb_pixel    (s_fb_pixel),
        .drop_flag   (s_drop_flag)
    );

    always @(negedge clock) begin
        if (s_fb_we) begin
            wr_t e;
            checks++;
            if (s_exp_q.size() == 0) begin
                errors++;
                $display("FAIL small_unexpected_write: got (%0d,%0d,%b) expected none", s_fb_x, s_fb_y, s_fb_pixel);
            end else begin
                e = s_exp_q.pop_front();
                if ({s_fb_x, s_fb_y, s_fb_pixel} !== e) begin
                    errors++;
                    $display("FAIL small_write: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                             s_fb_x, s_fb_y, s_fb_pixel, e.x, e.y, e.p);
                end
            end
        end
    end
`endif

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_drop", drop_flag, 0);
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("reset_fb_we", fb_we, 0);
        chk("reset_fb_x", fb_x, 0);
        chk("reset_fb_y", fb_y, 0);
        chk("reset_fb_pixel", fb_pixel, 0);
        chk("reset_clear_busy", clear_busy, 0);
        chk("reset_drop", drop_flag, 0);
        tick();
        reset_n = 1'b1;

        // Single request from req0
        tick();
        req0_valid = 1'b1; req0_x = 10'd5; req0_y = 10'd7; req0_pixel = 3'b101;
        #1;
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        exp_q.push_back(mk(5, 7, 3'b101));
        tick();
        req0_valid = 1'b0;
        chk("single_fb_we", fb_we, 1);
        tick();

        // Round robin with both requesters held valid
        do_reset();
        req0_valid = 1'b1; req0_x = 10'd1; req0_y = 10'd1; req0_pixel = 3'd1;
        req1_valid = 1'b1; req1_x = 10'd2; req1_y = 10'd2; req1_pixel = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) exp_q.push_back(mk(1, 1, 1));
            else            exp_q.push_back(mk(2, 2, 2));
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Blocked while scanning the visible area
        in_display = 1'b1;
        req1_valid = 1'b1; req1_x = 10'd100; req1_y = 10'd200; req1_pixel = 3'b110;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("disp_ready1", req1_ready, 0);
            tick();
        end
        in_display = 1'b0;
        #1;
        chk("disp_release_ready1", req1_ready, 1);
        exp_q.push_back(mk(100, 200, 3'b110));
        tick();
        req1_valid = 1'b0;
        chk("disp_fb_we", fb_we, 1);
        tick();

        // Boundary coordinates: last visible pixel written, out-of-range dropped
        req0_valid = 1'b1; req0_x = 10'd639; req0_y = 10'd479; req0_pixel = 3'b011;
        #1;
        chk("edge_ready0", req0_ready, 1);
        exp_q.push_back(mk(639, 479, 3'b011));
        tick();
        req0_x = 10'd640; req0_y = 10'd0; req0_pixel = 3'b111;
        #1;
        chk("oor_ready0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        chk("oor_drop", drop_flag, 1);
        req1_valid = 1'b1; req1_x = 10'd0; req1_y = 10'd480; req1_pixel = 3'b001;
        #1;
        chk("oor_y_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();
        chk("oor_drop_sticky", drop_flag, 1);
        do_reset();
        chk("drop_cleared", drop_flag, 0);

`ifndef FB_CLEAR_EN
        // Fill feature absent: clear_start ignored, request proceeds
        tick();
        clear_start = 1'b1; clear_pixel = 3'b011;
        req0_valid = 1'b1; req0_x = 10'd3; req0_y = 10'd4; req0_pixel = 3'b001;
        #1;
        chk("noclr_ready0", req0_ready, 1);
        exp_q.push_back(mk(3, 4, 1));
        tick();
        clear_start = 1'b0; req0_valid = 1'b0;
        chk("noclr_busy", clear_busy, 0);
        tick();
        chk("noclr_busy2", clear_busy, 0);
`endif
        repeat (3) tick();
        chk("main_queue_empty", exp_q.size(), 0);

`ifdef FB_CLEAR_EN
        begin
            int wcnt;
            bit done;
            logic d;
            tick();
            s_rst_n = 1'b1;
            tick();
            // Fill vs coincident request: fill wins
            s_clear_start = 1'b1; s_clear_pixel = 3'b010;
            s_req0_valid = 1'b1; s_req0_x = 10'd1; s_req0_y = 10'd1; s_req0_pixel = 3'b111;
            #1;
            chk("clr_coincident_ready0", s_req0_ready, 0);
            for (int y = 0; y < 2; y++)
                for (int x = 0; x < 4; x++)
                    s_exp_q.push_back(mk(x, y, 3'b010));
            s_exp_q.push_back(mk(1, 1, 3'b111));
            tick();
            s_clear_start = 1'b0;
            chk("clr_busy_rise", s_clear_busy, 1);
            wcnt = 0;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                s_in_display = (c % 3 == 1);
                s_clear_start = (c == 4);
                d = s_in_display;
                #1;
                chk("clr_ready0_blocked", s_req0_ready, 0);
                tick();
                chk("clr_we", s_fb_we, d ? 0 : 1);
                if (!d) wcnt++;
                if (wcnt == 8) begin
                    chk("clr_busy_fall", s_clear_busy, 0);
                    done = 1'b1;
                end else begin
                    chk("clr_busy_hold", s_clear_busy, 1);
                end
            end
            if (!done) chk("clr_timeout", wcnt, 8);
            s_in_display = 1'b0; s_clear_start = 1'b0;
            #1;
            chk("clr_after_ready0", s_req0_ready, 1);
            tick();
            s_req0_valid = 1'b0;
            repeat (2) tick();
            chk("clr_queue_empty", s_exp_q.size(), 0);

            // Reset in the middle of a fill
            s_clear_start = 1'b1; s_clear_pixel = 3'b101;
            tick();
            s_clear_start = 1'b0;
            for (int x = 0; x < 3; x++) s_exp_q.push_back(mk(x, 0, 3'b101));
            repeat (3) tick();
            @(negedge clock);
            #1;
            s_rst_n = 1'b0;
            #1;
            chk("abort_fb_we", s_fb_we, 0);
            chk("abort_fb_x", s_fb_x, 0);
            chk("abort_fb_pixel", s_fb_pixel, 0);
            chk("abort_busy", s_clear_busy, 0);
            tick();
            s_rst_n = 1'b1;
            repeat (10) tick();
            chk("abort_busy_after", s_clear_busy, 0);
            chk("abort_queue_empty", s_exp_q.size(), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
